// File: rtl/pe_feeder_pkg.sv
// Shared types and defaults for the PE load feeder.
// The `ifndef guards let a project-wide parameters.vh override these values.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef LOAD_NUM
`define LOAD_NUM 16
`endif
`ifndef ALPHA_NUM
`define ALPHA_NUM 4
`endif

package pe_feeder_pkg;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_BURST   = 2'd1,
        ST_WAIT_PE = 2'd2
    } state_t;

    localparam int FIFO_DEPTH_DEF = 32;
    localparam int GAP_DEF        = 2;

    // Bits needed to hold the value max_val.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pe_feeder_if.sv
// Sample-input and PE-side signals of the feeder, grouped as one bundle.
// Handshake: a sample moves on a rising edge where s_valid && s_ready; s_data must
// stay stable while s_valid is high and s_ready is low. din_pe_v/dout_pe_v are
// plain strobes with no back-pressure.
interface pe_feeder_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    logic                    s_valid;
    logic                    s_ready;
    logic [2*DATA_WIDTH-1:0] s_data;
    logic                    din_pe_v;
    logic [2*DATA_WIDTH-1:0] din_pe;
    logic                    dout_pe_v;

    modport master (
        output s_valid, s_data, dout_pe_v,
        input  s_ready, din_pe_v, din_pe
    );

    modport slave (
        input  s_valid, s_data, dout_pe_v,
        output s_ready, din_pe_v, din_pe
    );
endinterface

// File: rtl/pe_feeder_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout always shows the oldest entry.
// The caller guarantees no push when full and no pop when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/pe_feeder.sv
// Buffers an input sample stream and issues fixed-length load bursts to one PE,
// holding the next burst until the PE has returned its alpha outputs plus a guard gap.
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int LOAD_NUM   = `LOAD_NUM,
    parameter int ALPHA_NUM  = `ALPHA_NUM,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int GAP        = GAP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    pe_feeder_if.slave  bus,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        proto_err,
    output state_t      fsm_state
);
    localparam int SW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = cnt_w(LOAD_NUM);
    localparam int AW = cnt_w(ALPHA_NUM);
    localparam int GW = cnt_w(GAP);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   count;
    logic [SW-1:0]   fifo_dout;
    logic [BW-1:0]   beat_cnt;
    logic [AW-1:0]   alpha_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            push;
    logic            pop;
    logic            start;
    logic            alpha_last;

    assign bus.s_ready = ~rst & (count < CW'(FIFO_DEPTH));
    assign push        = bus.s_valid & bus.s_ready;
    assign alpha_last  = bus.dout_pe_v & (alpha_cnt == AW'(ALPHA_NUM - 1));
    assign fsm_state   = state;

    sync_fifo #(
        .WIDTH (SW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.s_data),
        .dout  (fifo_dout),
        .count (count)
    );

    // The first word is popped on the FILL->BURST edge so din_pe_v rises on that
    // same edge; BURST then pops the remaining LOAD_NUM-1 words.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        start      = 1'b0;
        case (state)
            ST_FILL: begin
                if (count >= CW'(LOAD_NUM) && gap_cnt == '0) begin
                    next_state = ST_BURST;
                    pop        = 1'b1;
                    start      = 1'b1;
                end
            end
            ST_BURST: begin
                pop = 1'b1;
                if (beat_cnt == BW'(LOAD_NUM - 1)) begin
                    next_state = ST_WAIT_PE;
                end
            end
            ST_WAIT_PE: begin
                if (alpha_last) begin
                    next_state = ST_FILL;
                end
            end
            default: next_state = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt     <= '0;
            alpha_cnt    <= '0;
            gap_cnt      <= '0;
            frame_cnt    <= '0;
            proto_err    <= 1'b0;
            busy         <= 1'b0;
            bus.din_pe_v <= 1'b0;
            bus.din_pe   <= '0;
        end else begin
            if (start) begin
                beat_cnt  <= BW'(1);
                frame_cnt <= frame_cnt + 16'd1;
            end else if (state == ST_BURST) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (state == ST_WAIT_PE && bus.dout_pe_v) begin
                alpha_cnt <= alpha_last ? '0 : alpha_cnt + 1'b1;
            end

            if (state == ST_WAIT_PE && alpha_last) begin
                gap_cnt <= GW'(GAP);
            end else if (state == ST_FILL && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            // Stray PE outputs are flagged but never counted toward a frame.
            if (bus.dout_pe_v && state != ST_WAIT_PE) begin
                proto_err <= 1'b1;
            end

            busy         <= (next_state != ST_FILL);
            bus.din_pe_v <= pop;
            bus.din_pe   <= pop ? fifo_dout : '0;
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: accepted samples feed an expected queue that is
// checked against every PE load beat; timing and status are checked inline.
module tb_pe_feeder;
    import pe_feeder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        proto_err;
    state_t      fsm_state;

    pe_feeder_if bus ();

    pe_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .proto_err (proto_err),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accepts = 0;
    int last_acc_cyc = 0;
    int last_alpha_cyc = 0;
    int beats = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record accepted samples and PE strobes at the edge the DUT sees them.
    always @(posedge clk) begin
        cyc++;
        if (!rst && bus.s_valid && bus.s_ready) begin
            exp_q.push_back(bus.s_data);
            accepts++;
            last_acc_cyc = cyc;
        end
        if (!rst && bus.dout_pe_v) last_alpha_cyc = cyc;
    end

    // Scoreboard: each load beat must be the oldest outstanding accepted sample.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.din_pe_v) begin
                beats++;
                if (exp_q.size() == 0) check("burst_underrun", 64'(exp_q.size()), 64'd1);
                else check("burst_data", 64'(bus.din_pe), 64'(exp_q.pop_front()));
            end else begin
                check("idle_zero", 64'(bus.din_pe), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_seq(input int n, input logic [31:0] base, input logic [31:0] step,
                             input bit rnd, input int idle);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = rnd ? $urandom : base + step * i;
            if (idle > 0 && i < n - 1) begin
                @(negedge clk);
                bus.s_valid = 1'b0;
                repeat (idle - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic alpha_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.dout_pe_v = 1'b1;
            @(negedge clk);
            bus.dout_pe_v = 1'b0;
        end
    endtask

    task automatic wait_rise(input string tag, output int rc);
        int t = 0;
        while (!bus.din_pe_v && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(bus.din_pe_v), 64'd1);
        rc = cyc;
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (bus.din_pe_v && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int rc;
        int n;
        int acc0;
        int seen;
        int b0;

        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.dout_pe_v = 1'b0;

        // Reset state
        #3;
        check("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check("rst_din_pe_v", 64'(bus.din_pe_v), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 64'(bus.s_ready), 64'd1);
        check("post_rst_state", 64'(fsm_state), 64'(ST_FILL));

        // Basic frame
        drive_seq(16, 32'h0001_0000, 32'h0001_0000, 1'b0, 0);
        check("basic_no_early", 64'(bus.din_pe_v), 64'd0);
        wait_rise("basic_rise", rc);
        check("basic_latency", 64'(rc - last_acc_cyc), 64'd1);
        check("basic_busy", 64'(busy), 64'd1);
        check("basic_frame_cnt", 64'(frame_cnt), 64'd1);
        wait_end(n);
        check("basic_len", 64'(n), 64'd16);
        check("basic_wait_state", 64'(fsm_state), 64'(ST_WAIT_PE));

        // Completion gating with a full FIFO
        drive_seq(32, 32'h0, 32'h0, 1'b1, 0);
        check("gate_fifo_full", 64'(bus.s_ready), 64'd0);
        repeat (20) @(negedge clk);
        check("gate_hold_v", 64'(bus.din_pe_v), 64'd0);
        check("gate_hold_frames", 64'(frame_cnt), 64'd1);
        alpha_pulses(4);
        wait_rise("gate_rise", rc);
        check("gate_latency", 64'(rc - last_alpha_cyc), 64'd3);
        check("gate_ready_on_pop", 64'(bus.s_ready), 64'd1);
        check("gate_frame_cnt", 64'(frame_cnt), 64'd2);
        wait_end(n);
        check("gate_len", 64'(n), 64'd16);
        alpha_pulses(4);
        wait_rise("gate_rise3", rc);
        check("gate_latency3", 64'(rc - last_alpha_cyc), 64'd3);
        wait_end(n);
        check("gate_len3", 64'(n), 64'd16);
        check("gate_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure with s_valid held high and no completion
        do_reset();
        acc0 = accepts;
        seen = accepts;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = $urandom;
        repeat (80) begin
            @(negedge clk);
            if (accepts != seen) begin
                seen = accepts;
                bus.s_data = $urandom;
            end
        end
        check("bp_accepts", 64'(accepts - acc0), 64'd48);
        check("bp_s_ready", 64'(bus.s_ready), 64'd0);
        check("bp_frame_cnt", 64'(frame_cnt), 64'd1);
        bus.s_valid = 1'b0;
        alpha_pulses(4);
        wait_rise("bp_rise", rc);
        check("bp_latency", 64'(rc - last_alpha_cyc), 64'd3);
        check("bp_ready_on_pop", 64'(bus.s_ready), 64'd1);
        wait_end(n);
        check("bp_len", 64'(n), 64'd16);
        alpha_pulses(4);
        wait_rise("bp_rise3", rc);
        wait_end(n);
        check("bp_len3", 64'(n), 64'd16);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Sparse input: one sample every three cycles
        do_reset();
        b0 = beats;
        drive_seq(16, 32'h0, 32'h0, 1'b1, 2);
        check("sparse_no_early", 64'(beats - b0), 64'd0);
        wait_rise("sparse_rise", rc);
        check("sparse_latency", 64'(rc - last_acc_cyc), 64'd1);
        wait_end(n);
        check("sparse_len", 64'(n), 64'd16);

        // Protocol error in FILL
        alpha_pulses(4);
        repeat (5) @(negedge clk);
        check("proto_clear", 64'(proto_err), 64'd0);
        alpha_pulses(1);
        check("proto_set", 64'(proto_err), 64'd1);
        repeat (10) @(negedge clk);
        check("proto_no_launch_v", 64'(bus.din_pe_v), 64'd0);
        check("proto_no_launch_fc", 64'(frame_cnt), 64'd1);
        check("proto_idle_busy", 64'(busy), 64'd0);
        check("proto_state", 64'(fsm_state), 64'(ST_FILL));

        // frame_cnt wrap, then the stray beat must not count toward this frame
        @(negedge clk);
        force dut.frame_cnt = 16'hffff;
        #1;
        release dut.frame_cnt;
        drive_seq(16, 32'h0, 32'h0, 1'b1, 0);
        wait_rise("wrap_rise", rc);
        check("wrap_frame_cnt", 64'(frame_cnt), 64'd0);
        wait_end(n);
        check("wrap_len", 64'(n), 64'd16);
        alpha_pulses(3);
        repeat (3) @(negedge clk);
        check("stray_not_counted", 64'(fsm_state), 64'(ST_WAIT_PE));
        check("stray_busy", 64'(busy), 64'd1);
        alpha_pulses(1);
        check("alpha_done_state", 64'(fsm_state), 64'(ST_FILL));
        check("alpha_done_busy", 64'(busy), 64'd0);
        check("proto_sticky", 64'(proto_err), 64'd1);

        // Reset in the middle of a burst
        repeat (4) @(negedge clk);
        drive_seq(16, 32'h0, 32'h0, 1'b1, 0);
        wait_rise("mid_rise", rc);
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_din_pe_v", 64'(bus.din_pe_v), 64'd0);
        check("mid_rst_din_pe", 64'(bus.din_pe), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("mid_rst_proto_err", 64'(proto_err), 64'd0);
        check("mid_rst_s_ready", 64'(bus.s_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_post_s_ready", 64'(bus.s_ready), 64'd1);
        b0 = beats;
        drive_seq(15, 32'h0, 32'h0, 1'b1, 0);
        repeat (10) @(negedge clk);
        check("mid_fifo_empty", 64'(beats - b0), 64'd0);
        drive_seq(1, 32'h0, 32'h0, 1'b1, 0);
        wait_rise("mid_new_rise", rc);
        check("mid_new_latency", 64'(rc - last_acc_cyc), 64'd1);
        check("mid_new_frame_cnt", 64'(frame_cnt), 64'd1);
        wait_end(n);
        check("mid_new_len", 64'(n), 64'd16);
        check("mid_drained", 64'(exp_q.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
